// File: rtl/anton_neopixel_bit_encoder.sv
// NeoPixel bit encoder: fetches one pixel byte per 64 ticks and shapes each data bit
// into an 8-tick high/low pattern, with frame counting and a sticky underrun flag.
`ifndef BUFFER_END_DEFAULT
`define BUFFER_END_DEFAULT 255
`endif

module anton_neopixel_bit_encoder #(
    parameter int         BUFFER_END   = `BUFFER_END_DEFAULT,
    parameter logic [7:0] PATTERN_ZERO = 8'b1110_0000,
    parameter logic [7:0] PATTERN_ONE  = 8'b1111_1000,
    localparam int        BUFFER_BITS  = $clog2(BUFFER_END + 1)
) (
    input  logic                   clk6_4mhz,
    input  logic                   rstn,
    input  logic                   regCtrlInit,
    input  logic                   regCtrlInvert,
    input  logic                   streamOutput,
    input  logic                   streamPixelOf,
    input  logic [2:0]             bitPatternIndex,
    input  logic [2:0]             pixelBitIndex,
    input  logic [BUFFER_BITS-1:0] pixelIndexComb,
    output logic                   bufferRead,
    output logic [BUFFER_BITS-1:0] bufferAddr,
    input  logic [7:0]             pixelByte,
    output logic                   neoData,
    output logic [15:0]            frameCount,
    output logic                   errorUnderrun
);

    logic                   first_tick;
    logic [BUFFER_BITS-1:0] addr_q, addr_d;
    logic                   s1_valid_q, s1_first_q, s1_last_q;
    logic [2:0]             s1_pat_q, s1_bit_q;
    logic [7:0]             byte_hold_q, byte_hold_d;
    logic                   byte_valid_q, byte_valid_d;
    logic                   neo_raw_q, neo_raw_d;
    logic [15:0]            frame_q, frame_d;
    logic                   err_q, err_d;
    logic [7:0]             cur_byte, pat;
    logic                   data_bit, level, underrun;

    always_comb begin
        first_tick = streamOutput && (bitPatternIndex == 3'd0) && (pixelBitIndex == 3'd0);
        addr_d     = first_tick ? pixelIndexComb : addr_q;
    end

    assign bufferRead    = first_tick;
    assign bufferAddr    = addr_d;
    assign frameCount    = frame_q;
    assign errorUnderrun = err_q;
    // Inversion sits after the register so the idle level follows it immediately.
    assign neoData       = neo_raw_q ^ regCtrlInvert;

    always_comb begin
        cur_byte     = s1_first_q ? pixelByte : byte_hold_q;
        data_bit     = cur_byte[3'd7 - s1_bit_q];
        pat          = data_bit ? PATTERN_ONE : PATTERN_ZERO;
        level        = pat[3'd7 - s1_pat_q];
        underrun     = s1_valid_q && !s1_first_q && !byte_valid_q;

        byte_hold_d  = s1_first_q ? pixelByte : byte_hold_q;
        byte_valid_d = byte_valid_q;
        if (s1_first_q)
            byte_valid_d = 1'b1;
        else if (!s1_valid_q)
            byte_valid_d = 1'b0;

        neo_raw_d = (s1_valid_q && (s1_first_q || byte_valid_q)) ? level : 1'b0;
        err_d     = err_q | underrun;
        frame_d   = s1_last_q ? frame_q + 16'd1 : frame_q;

        // Init wins over any simultaneous set/increment.
        if (regCtrlInit) begin
            byte_valid_d = 1'b0;
            neo_raw_d    = 1'b0;
            err_d        = 1'b0;
            frame_d      = 16'd0;
        end
    end

    always_ff @(posedge clk6_4mhz or negedge rstn) begin
        if (!rstn) begin
            addr_q       <= '0;
            s1_valid_q   <= 1'b0;
            s1_first_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            s1_pat_q     <= 3'd0;
            s1_bit_q     <= 3'd0;
            byte_hold_q  <= 8'd0;
            byte_valid_q <= 1'b0;
            neo_raw_q    <= 1'b0;
            frame_q      <= 16'd0;
            err_q        <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            s1_valid_q   <= streamOutput;
            s1_first_q   <= first_tick;
            s1_last_q    <= streamPixelOf;
            s1_pat_q     <= bitPatternIndex;
            s1_bit_q     <= pixelBitIndex;
            byte_hold_q  <= byte_hold_d;
            byte_valid_q <= byte_valid_d;
            neo_raw_q    <= neo_raw_d;
            frame_q      <= frame_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_anton_neopixel_bit_encoder.sv
// Directed bench for anton_neopixel_bit_encoder with a one-cycle-latency pixel RAM model.
module tb_anton_neopixel_bit_encoder;

    localparam int AW = 2;
    localparam logic [7:0] PAT_ZERO = 8'b1110_0000;
    localparam logic [7:0] PAT_ONE  = 8'b1111_1000;

    logic          clk = 1'b0;
    logic          rstn;
    logic          regCtrlInit, regCtrlInvert;
    logic          streamOutput, streamPixelOf;
    logic [2:0]    bitPatternIndex, pixelBitIndex;
    logic [AW-1:0] pixelIndexComb;
    logic          bufferRead;
    logic [AW-1:0] bufferAddr;
    logic [7:0]    pixelByte;
    logic          neoData;
    logic [15:0]   frameCount;
    logic          errorUnderrun;

    logic [7:0] mem [0:3];
    int checks = 0;
    int failures = 0;
    logic init_req = 1'b0;
    logic inv_req = 1'b0;
    logic [1:0] pipe_exp = 2'b00;
    logic [1:0] pipe_en = 2'b00;

    anton_neopixel_bit_encoder #(.BUFFER_END(3)) dut (
        .clk6_4mhz(clk), .rstn(rstn), .regCtrlInit(regCtrlInit), .regCtrlInvert(regCtrlInvert),
        .streamOutput(streamOutput), .streamPixelOf(streamPixelOf),
        .bitPatternIndex(bitPatternIndex), .pixelBitIndex(pixelBitIndex),
        .pixelIndexComb(pixelIndexComb), .bufferRead(bufferRead), .bufferAddr(bufferAddr),
        .pixelByte(pixelByte), .neoData(neoData), .frameCount(frameCount),
        .errorUnderrun(errorUnderrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (bufferRead) pixelByte <= mem[bufferAddr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_lvl(input logic [7:0] b, input logic [2:0] bt, input logic [2:0] pt);
        logic [7:0] p;
        p = b[3'd7 - bt] ? PAT_ONE : PAT_ZERO;
        return p[3'd7 - pt];
    endfunction

    // One clock: drive this tick, then check neoData for the tick driven two clocks ago.
    task automatic step(input logic so, input logic pof, input logic [2:0] pt, input logic [2:0] bt,
                        input logic [AW-1:0] ad, input logic ex);
        @(posedge clk); #1;
        streamOutput = so; streamPixelOf = pof; bitPatternIndex = pt; pixelBitIndex = bt;
        pixelIndexComb = ad; regCtrlInit = init_req; regCtrlInvert = inv_req;
        #1;
        if (pipe_en[1]) chk("neoData", neoData, pipe_exp[1] ^ regCtrlInvert);
        pipe_exp = {pipe_exp[0], ex};
        pipe_en  = {pipe_en[0], 1'b1};
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 3'd0, 3'd0, 2'd3, 1'b0);
    endtask

    task automatic send_byte(input logic [AW-1:0] ad, input logic [7:0] b, input logic last);
        for (int bt = 0; bt < 8; bt++) begin
            for (int pt = 0; pt < 8; pt++) begin
                step(1'b1, last && bt == 7 && pt == 7, 3'(pt), 3'(bt), ad, exp_lvl(b, 3'(bt), 3'(pt)));
                chk("bufferRead", bufferRead, 32'(bt == 0 && pt == 0));
                if (bt == 0 && pt == 0) chk("bufferAddr", bufferAddr, ad);
            end
        end
    endtask

    initial begin
        mem[0] = 8'hA5; mem[1] = 8'hFF; mem[2] = 8'h00; mem[3] = 8'h5A;
        rstn = 1'b0; regCtrlInit = 1'b0; regCtrlInvert = 1'b0; streamOutput = 1'b0;
        streamPixelOf = 1'b0; bitPatternIndex = 3'd0; pixelBitIndex = 3'd0; pixelIndexComb = 2'd2;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_neoData", neoData, 0);
        chk("rst_bufferRead", bufferRead, 0);
        chk("rst_bufferAddr", bufferAddr, 0);
        chk("rst_frameCount", frameCount, 0);
        chk("rst_errorUnderrun", errorUnderrun, 0);
        #2 rstn = 1'b1;
        idle(3);

        // Single byte 0xA5
        send_byte(2'd0, 8'hA5, 1'b0);
        idle(3);

        // 0xFF then 0x00 back-to-back, then address hold
        send_byte(2'd1, 8'hFF, 1'b0);
        send_byte(2'd2, 8'h00, 1'b0);
        idle(3);
        chk("addr_hold", bufferAddr, 2);

        // Three frames with stream reset periods
        for (int r = 0; r < 3; r++) begin
            for (int a = 0; a < 4; a++) send_byte(2'(a), mem[a], a == 3);
            idle(4);
        end
        chk("frames3", frameCount, 3);

        // Inverted output
        inv_req = 1'b1;
        idle(3);
        chk("idle_inv", neoData, 1);
        send_byte(2'd2, 8'h00, 1'b0);
        idle(3);
        inv_req = 1'b0;
        idle(3);

        // Underrun: gap at bit 3, resume at bit 4
        for (int bt = 0; bt < 3; bt++)
            for (int pt = 0; pt < 8; pt++)
                step(1'b1, 1'b0, 3'(pt), 3'(bt), 2'd0, exp_lvl(8'hA5, 3'(bt), 3'(pt)));
        for (int pt = 0; pt < 8; pt++) step(1'b0, 1'b0, 3'(pt), 3'd3, 2'd0, 1'b0);
        for (int bt = 4; bt < 8; bt++)
            for (int pt = 0; pt < 8; pt++)
                step(1'b1, 1'b0, 3'(pt), 3'(bt), 2'd0, 1'b0);
        idle(3);
        chk("underrun_set", errorUnderrun, 1);
        chk("underrun_frames", frameCount, 3);
        idle(2);
        chk("underrun_sticky", errorUnderrun, 1);
        init_req = 1'b1; idle(1); init_req = 1'b0; idle(1);
        chk("init_err", errorUnderrun, 0);
        chk("init_frames", frameCount, 0);

        // Asynchronous reset mid-byte
        send_byte(2'd1, 8'hFF, 1'b1);
        idle(3);
        chk("one_frame", frameCount, 1);
        for (int pt = 0; pt < 4; pt++) step(1'b1, 1'b0, 3'(pt), 3'd0, 2'd1, exp_lvl(8'hFF, 3'd0, 3'(pt)));
        #2 rstn = 1'b0;
        #1;
        chk("arst_neoData", neoData, 0);
        chk("arst_frameCount", frameCount, 0);
        chk("arst_bufferAddr", bufferAddr, 0);
        pipe_en = 2'b00;
        idle(2);
        rstn = 1'b1;
        idle(2);
        send_byte(2'd0, 8'hA5, 1'b0);
        idle(3);

        // frameCount wrap
        init_req = 1'b1; idle(1); init_req = 1'b0; idle(1);
        repeat (65535) step(1'b0, 1'b1, 3'd0, 3'd0, 2'd3, 1'b0);
        idle(2);
        chk("frames_ffff", frameCount, 16'hFFFF);
        step(1'b0, 1'b1, 3'd0, 3'd0, 2'd3, 1'b0);
        idle(2);
        chk("frames_wrap", frameCount, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
